// File: rtl/irq_pkg.sv
// Shared constants for the interrupt register and its controller-side feeder:
// register bit layout, source ID codes and the feeder FSM encoding.
package irq_pkg;

  localparam int unsigned REG_W   = 16;
  localparam int unsigned SRC_W   = 3;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned STATE_W = 2;

  localparam int unsigned ONOFF       = 15;
  localparam int unsigned IE_STATUS   = 6;
  localparam int unsigned IE_TRA      = 5;
  localparam int unsigned IE_REC      = 4;
  localparam int unsigned FLAG_STATUS = 2;
  localparam int unsigned FLAG_TRA    = 1;
  localparam int unsigned FLAG_REC    = 0;

  localparam logic [ID_W-1:0] ID_NONE   = 2'b00;
  localparam logic [ID_W-1:0] ID_REC    = 2'b01;
  localparam logic [ID_W-1:0] ID_TRA    = 2'b10;
  localparam logic [ID_W-1:0] ID_STATUS = 2'b11;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'b00;
  localparam logic [STATE_W-1:0] ST_XFER = 2'b01;
  localparam logic [STATE_W-1:0] ST_GAP  = 2'b10;

  // One bit per interrupt source, ordered as in the register word.
  typedef struct packed {
    logic status;
    logic tra;
    logic rec;
  } irq_src_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: status > transmit > receive > none.
module irq_prio_enc
  import irq_pkg::*;
(
  input  logic [SRC_W-1:0] act,
  output logic [ID_W-1:0]  id_c
);

  irq_src_t src;

  assign src = irq_src_t'(act);

  always_comb begin
    id_c = ID_NONE;
    if (src.status)   id_c = ID_STATUS;
    else if (src.tra) id_c = ID_TRA;
    else if (src.rec) id_c = ID_REC;
  end

endmodule

// File: rtl/irq_event_feeder.sv
// Buffers CAN controller event pulses, forwards them into the interrupt register
// through a one-cycle transfer slot, and derives the CPU interrupt line from it.
module irq_event_feeder
  import irq_pkg::*;
#(
  parameter int unsigned ONOFF_BIT = 15,
  parameter int unsigned IE_LSB    = 4,
  parameter int unsigned FLAG_LSB  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        evt_status,
  input  logic        evt_suctra,
  input  logic        evt_sucrec,
  input  logic [15:0] register_in,
  input  logic        ovr_clr,
  output logic        can,
  output logic        irqstatusc,
  output logic        irqsuctrac,
  output logic        irqsucrecc,
  output logic        irq_n,
  output logic [1:0]  irq_id,
  output logic [2:0]  ovr
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic [SRC_W-1:0]   evt;
  logic [SRC_W-1:0]   pending;
  logic [SRC_W-1:0]   pending_nxt;
  logic [SRC_W-1:0]   flag;
  logic [SRC_W-1:0]   ie;
  logic [SRC_W-1:0]   act;
  logic [ID_W-1:0]    id_c;
  logic               onoff;

  assign evt   = {evt_status, evt_suctra, evt_sucrec};
  assign flag  = register_in[FLAG_LSB +: SRC_W];
  assign ie    = register_in[IE_LSB +: SRC_W];
  assign onoff = register_in[ONOFF_BIT];
  assign act   = ie & flag;

  // Events landing during XFER start a fresh pending set for the next slot.
  assign pending_nxt = ((state == ST_XFER) ? SRC_W'(0) : pending) | evt;

  irq_prio_enc u_prio (
    .act  (act),
    .id_c (id_c)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // XFER is always followed by GAP so the CPU keeps a write slot.
  always_comb begin
    state_nxt  = state;
    can        = 1'b0;
    irqstatusc = 1'b0;
    irqsuctrac = 1'b0;
    irqsucrecc = 1'b0;
    case (state)
      ST_IDLE: if (pending_nxt != SRC_W'(0)) state_nxt = ST_XFER;
      ST_XFER: begin
        state_nxt = ST_GAP;
        can       = 1'b1;
        {irqstatusc, irqsuctrac, irqsucrecc} = pending;
      end
      ST_GAP:  state_nxt = (pending_nxt != SRC_W'(0)) ? ST_XFER : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Overflow marks an event merged into a flag or pending bit not yet serviced.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending <= '0;
      ovr     <= '0;
      irq_n   <= 1'b1;
      irq_id  <= ID_NONE;
    end else begin
      pending <= pending_nxt;
      ovr     <= (ovr_clr ? SRC_W'(0) : ovr) | (evt & (flag | pending));
      irq_n   <= ~(onoff & (|act));
      irq_id  <= onoff ? id_c : ID_NONE;
    end
  end

endmodule

// File: tb/tb_irq_event_feeder.sv
// Directed bench for irq_event_feeder with a cycle-level behavioural model of
// the feeder plus a model of the interrupt register it writes into.
module tb_irq_event_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        evt_status = 1'b0;
  logic        evt_suctra = 1'b0;
  logic        evt_sucrec = 1'b0;
  logic        ovr_clr = 1'b0;
  logic [15:0] register_in;
  logic        can, irqstatusc, irqsuctrac, irqsucrecc, irq_n;
  logic [1:0]  irq_id;
  logic [2:0]  ovr;

  logic [15:0] regv = 16'h0000;
  logic        cpu_wr = 1'b0;
  logic [15:0] cpu_data = 16'h0000;

  logic [2:0]  m_pend = 3'b000;
  logic        m_canq = 1'b0;
  logic [2:0]  m_ovr = 3'b000;
  logic        m_irq_n = 1'b1;
  logic [1:0]  m_id = 2'b00;
  logic        live = 1'b0;
  logic        m_can;
  logic [2:0]  evt;

  int total = 0;
  int bad = 0;

  localparam logic [2:0] TBL [12] = '{3'b001, 3'b011, 3'b100, 3'b000, 3'b111, 3'b010,
                                      3'b010, 3'b000, 3'b000, 3'b101, 3'b001, 3'b110};

  always #5 clk = ~clk;

  assign register_in = regv;
  assign evt   = {evt_status, evt_suctra, evt_sucrec};
  // A slot is granted when something is pending and the previous cycle was not a slot.
  assign m_can = (m_pend != 3'b000) && !m_canq;

  irq_event_feeder dut (
    .clk         (clk),
    .rst         (rst),
    .evt_status  (evt_status),
    .evt_suctra  (evt_suctra),
    .evt_sucrec  (evt_sucrec),
    .register_in (register_in),
    .ovr_clr     (ovr_clr),
    .can         (can),
    .irqstatusc  (irqstatusc),
    .irqsuctrac  (irqsuctrac),
    .irqsucrecc  (irqsucrecc),
    .irq_n       (irq_n),
    .irq_id      (irq_id),
    .ovr         (ovr)
  );

  function automatic logic [1:0] top_src(input logic [2:0] a);
    if (a[2]) return 2'b11;
    if (a[1]) return 2'b10;
    if (a[0]) return 2'b01;
    return 2'b00;
  endfunction

  // Interrupt register: controller set requests win over CPU writes.
  always @(posedge clk) begin
    if (m_can)       regv[2:0] <= regv[2:0] | m_pend;
    else if (cpu_wr) regv <= cpu_data;
  end

  always @(posedge clk) begin
    live <= 1'b1;
    if (!rst) begin
      m_pend  <= 3'b000;
      m_canq  <= 1'b0;
      m_ovr   <= 3'b000;
      m_irq_n <= 1'b1;
      m_id    <= 2'b00;
    end else begin
      m_pend  <= (m_can ? 3'b000 : m_pend) | evt;
      m_canq  <= m_can;
      m_ovr   <= (ovr_clr ? 3'b000 : m_ovr) | (evt & (regv[2:0] | m_pend));
      m_irq_n <= !(regv[15] && ((regv[6:4] & regv[2:0]) != 3'b000));
      m_id    <= regv[15] ? top_src(regv[6:4] & regv[2:0]) : 2'b00;
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_evt(input logic [2:0] e);
    {evt_status, evt_suctra, evt_sucrec} = e;
  endtask

  // Advance to the next falling edge and compare every output with the model.
  task automatic cyc();
    @(negedge clk);
    if (live) begin
      chk("can",    16'(can), 16'(m_can));
      chk("irqc",   16'({irqstatusc, irqsuctrac, irqsucrecc}), 16'(m_can ? m_pend : 3'b000));
      chk("irq_n",  16'(irq_n), 16'(m_irq_n));
      chk("irq_id", 16'(irq_id), 16'(m_id));
      chk("ovr",    16'(ovr), 16'(m_ovr));
    end
  endtask

  task automatic cpu_write(input logic [15:0] d);
    cpu_wr = 1'b1;
    cpu_data = d;
    cyc();
    cpu_wr = 1'b0;
  endtask

  initial begin
    // Reset held with event pulses present
    cyc();
    set_evt(3'b111); cpu_wr = 1'b1; cpu_data = 16'h8010;
    cyc();
    set_evt(3'b101); cpu_wr = 1'b0;
    cyc();
    chk("rst_can", 16'(can), 16'h0000);
    chk("rst_irq_n", 16'(irq_n), 16'h0001);
    chk("rst_id", 16'(irq_id), 16'h0000);
    chk("rst_ovr", 16'(ovr), 16'h0000);
    set_evt(3'b000); rst = 1'b1;
    cyc();
    chk("rst_pend", 16'(can), 16'h0000);

    // Single receive event
    set_evt(3'b001);
    cyc();
    set_evt(3'b000);
    chk("rx_can", 16'(can), 16'h0001);
    chk("rx_recc", 16'(irqsucrecc), 16'h0001);
    cyc();
    chk("rx_gap", 16'(can), 16'h0000);
    cyc();
    chk("rx_reg", regv, 16'h8011);
    chk("rx_irq_n", 16'(irq_n), 16'h0000);
    chk("rx_id", 16'(irq_id), 16'h0001);
    chk("rx_model_id", 16'(m_id), 16'h0001);

    // Coalescing, plus an event during XFER carried into a second slot
    cpu_write(16'h8070);
    set_evt(3'b110);
    cyc();
    set_evt(3'b001);
    chk("coal_can", 16'(can), 16'h0001);
    chk("coal_bits", 16'({irqstatusc, irqsuctrac, irqsucrecc}), 16'h0006);
    cyc();
    set_evt(3'b000);
    chk("coal_gap", 16'(can), 16'h0000);
    cyc();
    chk("coal_x2_can", 16'(can), 16'h0001);
    chk("coal_x2_bits", 16'({irqstatusc, irqsuctrac, irqsucrecc}), 16'h0001);
    cyc();
    cyc();
    chk("coal_reg", regv, 16'h8077);
    chk("coal_id", 16'(irq_id), 16'h0003);
    chk("coal_ovr", 16'(ovr), 16'h0000);

    // Priority and global enable
    cpu_write(16'h8073);
    cyc();
    chk("prio_id", 16'(irq_id), 16'h0002);
    chk("prio_irq_n", 16'(irq_n), 16'h0000);
    cpu_write(16'h0077);
    cyc();
    chk("off_irq_n", 16'(irq_n), 16'h0001);
    chk("off_id", 16'(irq_id), 16'h0000);
    chk("off_model_n", 16'(m_irq_n), 16'h0001);

    // Overflow set, set-over-clear, clear
    cpu_write(16'h8072);
    set_evt(3'b010);
    cyc();
    set_evt(3'b000);
    chk("ovr_set", 16'(ovr), 16'h0002);
    cyc();
    cyc();
    set_evt(3'b010); ovr_clr = 1'b1;
    cyc();
    set_evt(3'b000); ovr_clr = 1'b0;
    chk("ovr_setwins", 16'(ovr), 16'h0002);
    cyc();
    cyc();
    cyc();
    ovr_clr = 1'b1;
    cyc();
    ovr_clr = 1'b0;
    chk("ovr_clr", 16'(ovr), 16'h0000);
    chk("ovr_model_clr", 16'(m_ovr), 16'h0000);

    // Reset in the middle of a transfer
    cpu_write(16'h8070);
    set_evt(3'b100);
    cyc();
    set_evt(3'b000);
    chk("mid_xfer", 16'(can), 16'h0001);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    chk("mid_abort", 16'(can), 16'h0000);
    chk("mid_irq_n", 16'(irq_n), 16'h0001);
    cyc();
    chk("mid_pend", 16'(can), 16'h0000);

    // Event burst checked by the per-cycle model compare
    cpu_write(16'h8070);
    for (int i = 0; i < 12; i++) begin
      set_evt(TBL[i]);
      ovr_clr = (i % 5 == 4);
      cyc();
    end
    set_evt(3'b000);
    ovr_clr = 1'b0;
    for (int i = 0; i < 5; i++) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
